// File: rtl/tile_select_multi_pkg.sv
// Shared types and constants for the Trax move-selection controller.
package trax_sel_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_CLEAN,
        S_WAIT_RAM,
        S_ENG_GO,
        S_ENG_WAIT,
        S_LATCH,
        S_EMIT,
        S_FIRST,
        S_HOLD
    } sel_state_t;

    localparam logic [3:0] TILE_NONE  = 4'd0;
    localparam logic [3:0] TILE_FIRST = 4'd3;

    localparam int X_WIDTH_DEF = 10;
    localparam logic [X_WIDTH_DEF:0] WMAX = '1;

endpackage

// File: rtl/tile_select_multi_if.sv
// Search-engine handshake: selector launches a pass, engine answers with a weighted move.
interface tile_select_multi_if #(
    parameter int X_WIDTH = 10,
    parameter int PW      = 3
) ();
    logic               eng_start;
    logic [PW-1:0]      eng_pass;
    logic               eng_ready;
    logic [X_WIDTH:0]   eng_x;
    logic [X_WIDTH:0]   eng_y;
    logic [X_WIDTH:0]   eng_w;
    logic [3:0]         eng_t;

    modport master (
        output eng_start, eng_pass,
        input  eng_ready, eng_x, eng_y, eng_w, eng_t
    );

    modport slave (
        input  eng_start, eng_pass,
        output eng_ready, eng_x, eng_y, eng_w, eng_t
    );
endinterface

// File: rtl/tile_select_multi_best_keeper.sv
// Registered minimum-weight tracker; pass 0 always loads, later passes need a strictly lower weight.
module best_keeper
#(
    parameter int X_WIDTH = 10,
    parameter int PW      = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [PW-1:0]    pass_idx,
    input  logic [X_WIDTH:0] in_x,
    input  logic [X_WIDTH:0] in_y,
    input  logic [X_WIDTH:0] in_w,
    input  logic [3:0]       in_t,
    output logic [X_WIDTH:0] best_x,
    output logic [X_WIDTH:0] best_y,
    output logic [X_WIDTH:0] best_w,
    output logic [3:0]       best_t
);
    logic take;

    // Strict less-than keeps the earlier pass on ties.
    assign take = load && ((pass_idx == '0) || (in_w < best_w));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            best_w <= '1;
        end else if (take) begin
            best_w <= in_w;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            best_x <= in_x;
            best_y <= in_y;
            best_t <= in_t;
        end
    end

endmodule

// File: rtl/tile_select_multi.sv
// Multi-pass move selector: runs NUM_PASS engine searches and emits the lowest-weight move.
// Optional PASS_TIMEOUT_EN bounds each engine wait to TIMEOUT cycles.
module tile_select_multi
    import trax_sel_pkg::*;
#(
    parameter int         X_WIDTH   = 10,
    parameter int         NUM_PASS  = 2,
    parameter int         PW        = 3,
    parameter logic [3:0] FIRST_T   = TILE_FIRST,
    parameter int         RESET_OFF = 32,
    parameter int         TIMEOUT   = 4095
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             array_busy,
    input  logic             ram_ready,
    input  logic [X_WIDTH:0] old_off_x,
    input  logic [X_WIDTH:0] old_off_y,
    input  logic [X_WIDTH:0] old_max_off_x,
    input  logic [X_WIDTH:0] old_max_off_y,
    tile_select_multi_if.master eng,
    output logic             clean_mark,
    output logic [X_WIDTH:0] offset_x_out,
    output logic [X_WIDTH:0] offset_y_out,
    output logic [X_WIDTH:0] out_x,
    output logic [X_WIDTH:0] out_y,
    output logic [3:0]       out_t,
    output logic             w_end,
    output logic             busy
);
    sel_state_t       state, state_nx;
    logic [PW-1:0]    pass_q;
    logic [X_WIDTH:0] off_x, off_y, max_off_x, max_off_y;
    logic [X_WIDTH:0] best_x, best_y, best_w;
    logic [3:0]       best_t;
    logic [X_WIDTH:0] latch_w;
    logic             wait_expired;
    logic             board_empty;
    logic             last_pass;

    assign board_empty  = (off_x == max_off_x) && (off_y == max_off_y);
    assign last_pass    = (pass_q == PW'(NUM_PASS - 1));
    assign offset_x_out = off_x;
    assign offset_y_out = off_y;
    assign busy         = (state != S_IDLE);
    assign eng.eng_pass = pass_q;

`ifdef PASS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
    logic          timed_out;

    assign wait_expired = (state == S_ENG_WAIT) && !eng.eng_ready &&
                          (wait_cnt == TW'(TIMEOUT - 1));

    // A timed-out pass enters LATCH with an all-ones weight, so only pass 0 can keep it.
    always_ff @(posedge clk) begin
        if (reset || state == S_ENG_GO) begin
            wait_cnt  <= '0;
            timed_out <= 1'b0;
        end else if (state == S_ENG_WAIT) begin
            wait_cnt  <= wait_cnt + 1'b1;
            timed_out <= wait_expired;
        end
    end

    assign latch_w = timed_out ? '1 : eng.eng_w;
`else
    assign wait_expired = 1'b0;
    assign latch_w      = eng.eng_w;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        clean_mark    = 1'b0;
        eng.eng_start = 1'b0;
        case (state)
            S_IDLE:     if (start) state_nx = S_LOAD;
            S_LOAD:     state_nx = S_CHECK;
            S_CHECK:    state_nx = board_empty ? S_FIRST : S_CLEAN;
            S_CLEAN: begin
                clean_mark = 1'b1;
                state_nx   = S_WAIT_RAM;
            end
            S_WAIT_RAM: if (ram_ready) state_nx = S_ENG_GO;
            S_ENG_GO: begin
                eng.eng_start = 1'b1;
                state_nx      = S_ENG_WAIT;
            end
            S_ENG_WAIT: if (eng.eng_ready || wait_expired) state_nx = S_LATCH;
            S_LATCH:    state_nx = last_pass ? S_EMIT : S_CLEAN;
            S_EMIT:     state_nx = S_HOLD;
            S_FIRST:    state_nx = S_HOLD;
            S_HOLD:     if (!array_busy) state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            off_x     <= (X_WIDTH+1)'(RESET_OFF);
            off_y     <= (X_WIDTH+1)'(RESET_OFF);
            max_off_x <= (X_WIDTH+1)'(RESET_OFF);
            max_off_y <= (X_WIDTH+1)'(RESET_OFF);
        end else if (state == S_IDLE && start) begin
            off_x     <= old_off_x;
            off_y     <= old_off_y;
            max_off_x <= old_max_off_x;
            max_off_y <= old_max_off_y;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || state == S_CHECK) begin
            pass_q <= '0;
        end else if (state == S_LATCH && !last_pass) begin
            pass_q <= pass_q + 1'b1;
        end
    end

    // out_* and w_end are registered so they appear together and hold through IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_x <= '0;
            out_y <= '0;
            out_t <= '0;
            w_end <= 1'b0;
        end else if (state == S_CHECK && board_empty) begin
            out_x <= off_x;
            out_y <= off_y;
            out_t <= FIRST_T;
            w_end <= 1'b1;
        end else if (state == S_EMIT) begin
            out_x <= best_x;
            out_y <= best_y;
            out_t <= best_t;
            w_end <= 1'b1;
        end else begin
            w_end <= 1'b0;
        end
    end

    best_keeper #(
        .X_WIDTH (X_WIDTH),
        .PW      (PW)
    ) u_best (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == S_CHECK),
        .load     (state == S_LATCH),
        .pass_idx (pass_q),
        .in_x     (eng.eng_x),
        .in_y     (eng.eng_y),
        .in_w     (latch_w),
        .in_t     (eng.eng_t),
        .best_x   (best_x),
        .best_y   (best_y),
        .best_w   (best_w),
        .best_t   (best_t)
    );

endmodule

// File: tb/tb_tile_select_multi.sv
// Bench for tile_select_multi: a 2-pass and a 3-pass instance against a behavioural move model.
module tb_tile_select_multi;
    localparam int XW    = 10;
    localparam int LIMIT = 500;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic start_v = 1'b0;
    int   sel = 0;
    logic start2, start3;
    assign start2 = start_v && (sel == 0);
    assign start3 = start_v && (sel == 1);

    logic array_busy = 1'b0;
    logic ram_ready  = 1'b1;
    bit   rr_rand    = 1'b0;
    logic [XW:0] old_off_x = '0, old_off_y = '0, old_max_off_x = '0, old_max_off_y = '0;

    tile_select_multi_if #(.X_WIDTH(XW), .PW(3)) eif2 ();
    tile_select_multi_if #(.X_WIDTH(XW), .PW(3)) eif3 ();

    logic        cm2, cm3, we2, we3, busy2, busy3;
    logic [XW:0] ox2, oy2, ox3, oy3, outx2, outy2, outx3, outy3;
    logic [3:0]  outt2, outt3;

    tile_select_multi #(.X_WIDTH(XW), .NUM_PASS(2), .PW(3), .FIRST_T(4'd3),
                        .RESET_OFF(32), .TIMEOUT(20)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .array_busy(array_busy), .ram_ready(ram_ready),
        .old_off_x(old_off_x), .old_off_y(old_off_y),
        .old_max_off_x(old_max_off_x), .old_max_off_y(old_max_off_y),
        .eng(eif2), .clean_mark(cm2), .offset_x_out(ox2), .offset_y_out(oy2),
        .out_x(outx2), .out_y(outy2), .out_t(outt2), .w_end(we2), .busy(busy2));

    tile_select_multi #(.X_WIDTH(XW), .NUM_PASS(3), .PW(3), .FIRST_T(4'd3),
                        .RESET_OFF(32), .TIMEOUT(20)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .array_busy(array_busy), .ram_ready(ram_ready),
        .old_off_x(old_off_x), .old_off_y(old_off_y),
        .old_max_off_x(old_max_off_x), .old_max_off_y(old_max_off_y),
        .eng(eif3), .clean_mark(cm3), .offset_x_out(ox3), .offset_y_out(oy3),
        .out_x(outx3), .out_y(outy3), .out_t(outt3), .w_end(we3), .busy(busy3));

    logic        w_end_s, busy_s;
    logic [XW:0] out_x_s, out_y_s, off_x_s, off_y_s;
    logic [3:0]  out_t_s;
    assign w_end_s = (sel == 0) ? we2   : we3;
    assign busy_s  = (sel == 0) ? busy2 : busy3;
    assign out_x_s = (sel == 0) ? outx2 : outx3;
    assign out_y_s = (sel == 0) ? outy2 : outy3;
    assign out_t_s = (sel == 0) ? outt2 : outt3;
    assign off_x_s = (sel == 0) ? ox2   : ox3;
    assign off_y_s = (sel == 0) ? oy2   : oy3;

    // Per-instance engine script, indexed by pass.
    logic [XW:0] e_x [2][8];
    logic [XW:0] e_y [2][8];
    logic [XW:0] e_w [2][8];
    logic [3:0]  e_t [2][8];
    int          e_dly [2][8];
    bit          e_never [2][8];

    int n_vec = 0;
    int n_err = 0;
    int cm_cnt [2] = '{0, 0};
    int es_cnt [2] = '{0, 0};
    int we_cnt [2] = '{0, 0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin : pulse_counters
        forever begin
            @(negedge clk);
            if (cm2) cm_cnt[0]++;
            if (cm3) cm_cnt[1]++;
            if (eif2.eng_start) es_cnt[0]++;
            if (eif3.eng_start) es_cnt[1]++;
            if (we2) we_cnt[0]++;
            if (we3) we_cnt[1]++;
        end
    end

    initial begin : ram_model
        forever begin
            @(negedge clk);
            ram_ready = rr_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin : eng2_model
        int cnt;
        int p;
        cnt = -1; p = 0;
        eif2.eng_ready = 1'b0;
        eif2.eng_x = '0; eif2.eng_y = '0; eif2.eng_w = '0; eif2.eng_t = '0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                eif2.eng_ready = 1'b0; cnt = -1;
            end else if (eif2.eng_start) begin
                p = int'(eif2.eng_pass);
                eif2.eng_ready = 1'b0;
                eif2.eng_x = e_x[0][p]; eif2.eng_y = e_y[0][p];
                eif2.eng_w = e_w[0][p]; eif2.eng_t = e_t[0][p];
                cnt = e_never[0][p] ? -1 : e_dly[0][p];
            end
            if (cnt == 0) begin
                eif2.eng_ready = 1'b1; cnt = -1;
            end else if (cnt > 0) cnt--;
        end
    end

    initial begin : eng3_model
        int cnt;
        int p;
        cnt = -1; p = 0;
        eif3.eng_ready = 1'b0;
        eif3.eng_x = '0; eif3.eng_y = '0; eif3.eng_w = '0; eif3.eng_t = '0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                eif3.eng_ready = 1'b0; cnt = -1;
            end else if (eif3.eng_start) begin
                p = int'(eif3.eng_pass);
                eif3.eng_ready = 1'b0;
                eif3.eng_x = e_x[1][p]; eif3.eng_y = e_y[1][p];
                eif3.eng_w = e_w[1][p]; eif3.eng_t = e_t[1][p];
                cnt = e_never[1][p] ? -1 : e_dly[1][p];
            end
            if (cnt == 0) begin
                eif3.eng_ready = 1'b1; cnt = -1;
            end else if (cnt > 0) cnt--;
        end
    end

    task automatic set_pass(input int s, input int p, input logic [XW:0] w, input int dly);
        e_x[s][p] = XW'($urandom_range(0, 2047));
        e_y[s][p] = XW'($urandom_range(0, 2047));
        e_t[s][p] = 4'($urandom_range(0, 15));
        e_w[s][p] = w;
        e_dly[s][p] = dly;
        e_never[s][p] = 1'b0;
    endtask

    task automatic set_board(input logic [XW:0] ox, input logic [XW:0] mx,
                             input logic [XW:0] oy, input logic [XW:0] my);
        old_off_x = ox; old_max_off_x = mx;
        old_off_y = oy; old_max_off_y = my;
    endtask

    // Expected move: first-tile on an empty board, otherwise the earliest pass of minimum weight.
    function automatic void model(input int s, input int np, output logic [XW:0] ex,
                                  output logic [XW:0] ey, output logic [3:0] et, output bit empty);
        int best;
        logic [XW:0] bw, w;
        empty = (old_off_x == old_max_off_x) && (old_off_y == old_max_off_y);
        if (empty) begin
            ex = old_off_x; ey = old_off_y; et = 4'd3;
        end else begin
            best = 0;
            bw = e_never[s][0] ? '1 : e_w[s][0];
            for (int i = 1; i < np; i++) begin
                w = e_never[s][i] ? '1 : e_w[s][i];
                if (w < bw) begin best = i; bw = w; end
            end
            ex = e_x[s][best]; ey = e_y[s][best]; et = e_t[s][best];
        end
    endfunction

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1; start_v = 1'b0; array_busy = 1'b0;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic run_move(input int s, input bit chk_lat, input int extra, input int hold_cyc);
        int np, cyc, cm0, es0, we0;
        logic [XW:0] ex, ey;
        logic [3:0] et;
        bit empty;
        np = (s == 0) ? 2 : 3;
        sel = s;
        model(s, np, ex, ey, et, empty);
        cm0 = cm_cnt[s]; es0 = es_cnt[s]; we0 = we_cnt[s];
        array_busy = (hold_cyc > 0);
        @(negedge clk); start_v = 1'b1;
        @(posedge clk); #1; start_v = 1'b0; cyc = 1;
        while (!w_end_s && cyc < LIMIT) begin
            @(posedge clk); #1; cyc++;
        end
        if (!w_end_s) begin
            check_eq("wend_timeout", 32'(w_end_s), 32'd1);
            pulse_reset();
            return;
        end
        check_eq("out_x", 32'(out_x_s), 32'(ex));
        check_eq("out_y", 32'(out_y_s), 32'(ey));
        check_eq("out_t", 32'(out_t_s), 32'(et));
        if (chk_lat) check_eq("latency", 32'(cyc), empty ? 32'd3 : 32'(5 * np + 4 + extra));
        check_eq("busy_at_wend", 32'(busy_s), 32'd1);
        @(posedge clk); #1;
        check_eq("wend_pulse", 32'(w_end_s), 32'd0);
        check_eq("clean_marks", 32'(cm_cnt[s] - cm0), empty ? 32'd0 : 32'(np));
        check_eq("eng_starts", 32'(es_cnt[s] - es0), empty ? 32'd0 : 32'(np));
        if (hold_cyc > 0) begin
            repeat (hold_cyc) begin
                @(negedge clk); start_v = 1'b1;
            end
            @(negedge clk); start_v = 1'b0;
            check_eq("hold_busy", 32'(busy_s), 32'd1);
            check_eq("hold_out_x", 32'(out_x_s), 32'(ex));
            array_busy = 1'b0;
        end
        cyc = 0;
        while (busy_s && cyc < 8) begin
            @(posedge clk); #1; cyc++;
        end
        check_eq("idle_after_hold", 32'(busy_s), 32'd0);
        @(posedge clk); #1;
        check_eq("idle_stays", 32'(busy_s), 32'd0);
        check_eq("idle_out_y", 32'(out_y_s), 32'(ey));
        check_eq("wend_count", 32'(we_cnt[s] - we0), 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int s, np;
        logic [XW:0] v;
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 8; p++) set_pass(i, p, 11'd0, 0);

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy2", 32'(busy2), 32'd0);
        check_eq("rst_busy3", 32'(busy3), 32'd0);
        check_eq("rst_offx2", 32'(ox2), 32'd32);
        check_eq("rst_offy3", 32'(oy3), 32'd32);
        check_eq("rst_outx2", 32'(outx2), 32'd0);
        check_eq("rst_outt3", 32'(outt3), 32'd0);
        check_eq("rst_wend2", 32'(we2), 32'd0);
        check_eq("rst_clean3", 32'(cm3), 32'd0);
        check_eq("rst_estart2", 32'(eif2.eng_start), 32'd0);
        @(negedge clk); reset = 1'b0;

        // Empty board at the reset extents.
        set_board(11'd32, 11'd32, 11'd32, 11'd32);
        run_move(1, 1'b1, 0, 0);

        // Two passes, weights 5 then 7: pass 0 wins.
        set_board(11'd3, 11'd20, 11'd4, 11'd18);
        set_pass(0, 0, 11'd5, 0); set_pass(0, 1, 11'd7, 0);
        run_move(0, 1'b1, 0, 0);

        // Three passes, weights 9,4,4: tie goes to pass 1.
        set_pass(1, 0, 11'd9, 0); set_pass(1, 1, 11'd4, 0); set_pass(1, 2, 11'd4, 0);
        run_move(1, 1'b1, 0, 0);

        // array_busy keeps HOLD for 10 cycles while start is pulsed.
        set_pass(0, 0, 11'd8, 0); set_pass(0, 1, 11'd2, 0);
        run_move(0, 1'b1, 0, 10);

        // Every pass all-ones: pass 0 result kept.
        set_pass(1, 0, 11'h7FF, 0); set_pass(1, 1, 11'h7FF, 0); set_pass(1, 2, 11'h7FF, 0);
        run_move(1, 1'b1, 0, 0);

        // Only one axis at its extent is not an empty board; then an empty one elsewhere.
        set_board(11'd7, 11'd7, 11'd9, 11'd12);
        set_pass(0, 0, 11'd3, 0); set_pass(0, 1, 11'd1, 0);
        run_move(0, 1'b1, 0, 0);
        set_board(11'd7, 11'd7, 11'd9, 11'd9);
        run_move(0, 1'b1, 0, 0);

        // Randomized moves with engine and RAM stalls.
        rr_rand = 1'b1;
        for (int it = 0; it < 24; it++) begin
            s = int'($urandom_range(0, 1));
            np = (s == 0) ? 2 : 3;
            for (int p = 0; p < np; p++) begin
                v = ($urandom_range(0, 7) == 0) ? 11'h7FF : 11'($urandom_range(0, 15));
                set_pass(s, p, v, int'($urandom_range(0, 3)));
            end
            v = 11'($urandom_range(0, 63));
            if ($urandom_range(0, 4) == 0) set_board(v, v, v + 11'd1, v + 11'd1);
            else set_board(v, v + 11'($urandom_range(1, 9)), v, v + 11'($urandom_range(0, 9)));
            run_move(s, 1'b0, 0, ($urandom_range(0, 3) == 0) ? 3 : 0);
        end
        rr_rand = 1'b0;

        // Reset while the engine is being waited on.
        sel = 0;
        set_board(11'd5, 11'd9, 11'd6, 11'd11);
        set_pass(0, 0, 11'd5, 0);
        e_never[0][0] = 1'b1;
        @(negedge clk); start_v = 1'b1;
        @(posedge clk); #1; start_v = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_eq("pre_reset_busy", 32'(busy2), 32'd1);
        s = we_cnt[0];
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_busy", 32'(busy2), 32'd0);
        check_eq("midrst_offx", 32'(ox2), 32'd32);
        check_eq("midrst_offy", 32'(oy2), 32'd32);
        check_eq("midrst_wend", 32'(we2), 32'd0);
        @(negedge clk); reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("postrst_idle", 32'(busy2), 32'd0);
        check_eq("postrst_no_wend", 32'(we_cnt[0] - s), 32'd0);
        e_never[0][0] = 1'b0;

`ifdef PASS_TIMEOUT_EN
        // Pass 1 never answers: 20-cycle wait, then pass 0 result emitted.
        set_board(11'd2, 11'd30, 11'd2, 11'd30);
        set_pass(0, 0, 11'd6, 0); set_pass(0, 1, 11'd1, 0);
        e_never[0][1] = 1'b1;
        run_move(0, 1'b1, 19, 0);
        e_never[0][1] = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
